dmm_port_arbiter: RTL and testbench
===================================

# dmm_port_arbiter

Arbitrates the single 256-bit dynamic-memory-manager memory port between two requesters. The first is the allocator master port: 32-bit word read/write with a 4-bit length. The second is the atomic unit: full 256-bit line, size 8. The block replaces the combinational state-based port mux in the memory manager. It serialises transactions, latches request fields, applies round-robin fairness and returns registered completion to the requester that issued each transaction.

## Interface
- `WORD_LANE_LSB`, default 224: bit offset of the allocator's 32-bit word lane inside the 256-bit bus, used for both write and read data.
- Reset is asynchronous and active-high. The clock port is named `clk` and the reset port `rst`. All logic is in the single `clk` domain.
- `clk`  in  1  clock
- `rst`  in  1  asynchronous active-high reset
- `alloc_req_i`  in  1  allocator request (level, held until `alloc_done_o`)
- `alloc_addr_i`  in  32  allocator address
- `alloc_rw_i`  in  1  1 = write
- `alloc_data_i`  in  32  allocator write word
- `alloc_len_i`  in  4  allocator transfer size in bytes
- `alloc_done_o`  out  1  one-cycle completion pulse
- `alloc_data_o`  out  32  read word, valid while `alloc_done_o` is high
- `atom_req_i`  in  1  atomic-unit request (level)
- `atom_addr_i`  in  32  atomic address
- `atom_rw_i`  in  1  1 = write
- `atom_data_i`  in  256  atomic write line
- `atom_done_o`  out  1  one-cycle completion pulse
- `atom_data_o`  out  256  read line, valid while `atom_done_o` is high
- `mem_strobe_o`  out  1  one-cycle request strobe to the memory unit
- `mem_addr_o`, `mem_rw_o`, `mem_data_o[255:0]`, `mem_size_o[7:0]`  out  latched transaction fields
- `mem_done_i`  in  1  memory completion
- `mem_data_i`  in  256  memory read data
- `busy_o`  out  1  high in any state other than IDLE
- `owner_o`  out  1  current/last grant, 0 = alloc, 1 = atom

## Operation
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- **IDLE**
  - If exactly one requester is active, grant it.
  - If both are active, grant the requester that is not `last_owner` (round-robin).
  - On grant, latch addr, rw, data and size into registers, set `owner_o`, and go to ISSUE.
- **Field formation**
  - alloc: `mem_data_o = alloc_data_i << WORD_LANE_LSB`, all other bits 0.
  - alloc: `mem_size_o = {4'b0, alloc_len_i}`.
  - atom: `mem_data_o = atom_data_i`, `mem_size_o = 8`.
- **ISSUE**: `mem_strobe_o = 1` for exactly this cycle; go to WAIT.
- **WAIT**: hold all `mem_*` fields stable.
  - On `mem_done_i`, register read data and go to RESP.
  - alloc read data: `mem_data_i[WORD_LANE_LSB+31:WORD_LANE_LSB]`.
  - atom read data: full line.
- **RESP**: pulse the owner's `*_done_o`; update `last_owner = owner_o`; go to IDLE.
- **Requester rule**: a requester deasserts `*_req_i` on the edge where it samples its done pulse. The next IDLE cycle therefore sees that requester as inactive.
- `mem_done_i` is ignored in IDLE, ISSUE and RESP.
- Request inputs that change while a transaction is granted have no effect until the next IDLE.
- Reset values:
  - state = IDLE, `last_owner = 1` (alloc wins the first tie).
  - All outputs are 0, including `owner_o` and the `mem_*` fields.
- **Reset mid-transaction**: the FSM returns to IDLE immediately and the outstanding memory transaction is abandoned. A late `mem_done_i` after reset is ignored, and no done pulse is produced.

## Timing
- The grant decision is made in IDLE cycle T.
- Strobe at T+1.
- Earliest `mem_done_i` at T+2.
- Done pulse to the requester at T+3 at the earliest, i.e. one cycle after `mem_done_i`.
- Minimum back-to-back spacing is 4 cycles per transaction.
- A requester waiting behind another is served within one transaction, which bounds starvation.
- All outputs are registered: no combinational path from any input to any output.

## Structure
- Shared package holds:
  - the FSM state encoding (IDLE, ISSUE, WAIT, RESP)
  - owner constants `OWN_ALLOC = 0`, `OWN_ATOM = 1`
  - `ATOM_SIZE = 8`
- One sub-module, `rr_arbiter2`: a 2-way round-robin grant from two request bits and `last_owner`. It is purely combinational and reused by later port arbiters.

## Test plan
- **Alloc write alone**
  - Stimulus: addr 0x70000010, data 0xDEADBEEF, len 4.
  - Response: one strobe with `mem_data_o[255:224] = 0xDEADBEEF`, lower bits 0, `mem_size_o = 4`, `mem_rw_o = 1`.
  - Mem done delay 3 → `alloc_done_o` one cycle after `mem_done_i`.
- **Atomic read alone**
  - Stimulus: addr 0x70000040; mem returns line 0x0123…CDEF.
  - Response: `mem_size_o = 8`, `atom_data_o` equals the line, `atom_done_o` is a single pulse.
- **Simultaneous requests from reset**
  - Response: alloc served first, atom second, with strobes spaced ≥4 cycles.
  - Repeated ties alternate A, T, A, T across 4 transactions.
- **Spurious memory done and field stability**
  - Stimulus: `mem_done_i` pulsed in IDLE and in ISSUE.
  - Response: no done output, no state change.
  - `mem_addr_o` stays stable in WAIT while `alloc_addr_i` toggles.
- **Reset mid-transaction**
  - Stimulus: `rst` asserted in WAIT, then `mem_done_i` arrives 2 cycles after reset release.
  - Response: all outputs 0 and `busy_o = 0`; the late `mem_done_i` produces no done pulse.
- **Alloc read lane extraction**
  - Stimulus: mem returns 0xA5A5A5A5 in bits [255:224] and 0xFFFFFFFF elsewhere.
  - Response: `alloc_data_o = 0xA5A5A5A5`.

Source files
------------

// File: rtl/dmm_port_arbiter_pkg.sv
// dmm_port_arbiter_pkg: shared state encoding and owner/size constants for the DMM memory-port arbiters.
package dmm_port_arbiter_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
  localparam logic OWN_ALLOC = 1'b0;
  localparam logic OWN_ATOM = 1'b1;
  localparam logic [7:0] ATOM_SIZE = 8'd8;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational 2-way round-robin grant; on a tie the requester that was not last served wins.
module rr_arbiter2
  import dmm_port_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_owner_i,
  output logic       gnt_valid_o,
  output logic       gnt_owner_o
);
  assign gnt_valid_o = |req_i;
  assign gnt_owner_o = &req_i ? ~last_owner_i : req_i[OWN_ATOM];
endmodule

// File: rtl/dmm_port_arbiter.sv
// dmm_port_arbiter: serialises allocator-word and atomic-line transactions onto the single 256-bit memory port.
module dmm_port_arbiter
  import dmm_port_arbiter_pkg::*;
#(
  parameter int WORD_LANE_LSB = 224
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         alloc_req_i,
  input  logic [31:0]  alloc_addr_i,
  input  logic         alloc_rw_i,
  input  logic [31:0]  alloc_data_i,
  input  logic [3:0]   alloc_len_i,
  output logic         alloc_done_o,
  output logic [31:0]  alloc_data_o,
  input  logic         atom_req_i,
  input  logic [31:0]  atom_addr_i,
  input  logic         atom_rw_i,
  input  logic [255:0] atom_data_i,
  output logic         atom_done_o,
  output logic [255:0] atom_data_o,
  output logic         mem_strobe_o,
  output logic [31:0]  mem_addr_o,
  output logic         mem_rw_o,
  output logic [255:0] mem_data_o,
  output logic [7:0]   mem_size_o,
  input  logic         mem_done_i,
  input  logic [255:0] mem_data_i,
  output logic         busy_o,
  output logic         owner_o
);
  state_e state_q, state_d;
  logic owner_q, owner_d, last_q, last_d, strobe_q, strobe_d, rw_q, rw_d;
  logic alloc_done_q, alloc_done_d, atom_done_q, atom_done_d;
  logic [31:0] addr_q, addr_d, alloc_rd_q, alloc_rd_d;
  logic [255:0] wdata_q, wdata_d, atom_rd_q, atom_rd_d;
  logic [7:0] size_q, size_d;
  logic gnt_valid, gnt_owner, grant, mem_hit;
  rr_arbiter2 u_rr (
    .req_i       ({atom_req_i, alloc_req_i}),
    .last_owner_i(last_q),
    .gnt_valid_o (gnt_valid),
    .gnt_owner_o (gnt_owner)
  );
  assign grant = state_q == S_IDLE && gnt_valid;
  assign mem_hit = state_q == S_WAIT && mem_done_i;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = gnt_valid ? S_ISSUE : S_IDLE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  state_d = mem_done_i ? S_RESP : S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    owner_d = grant ? gnt_owner : owner_q;
    addr_d = grant ? (gnt_owner ? atom_addr_i : alloc_addr_i) : addr_q;
    rw_d = grant ? (gnt_owner ? atom_rw_i : alloc_rw_i) : rw_q;
    wdata_d = grant ? (gnt_owner ? atom_data_i : 256'(alloc_data_i) << WORD_LANE_LSB) : wdata_q;
    size_d = grant ? (gnt_owner ? ATOM_SIZE : {4'b0, alloc_len_i}) : size_q;
    strobe_d = grant;
    last_d = state_q == S_RESP ? owner_q : last_q;
    alloc_done_d = mem_hit && owner_q == OWN_ALLOC;
    atom_done_d = mem_hit && owner_q == OWN_ATOM;
    alloc_rd_d = alloc_done_d ? mem_data_i[WORD_LANE_LSB +: 32] : alloc_rd_q;
    atom_rd_d = atom_done_d ? mem_data_i : atom_rd_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= OWN_ALLOC;
      last_q <= OWN_ATOM;
      strobe_q <= 1'b0;
      rw_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      size_q <= '0;
      alloc_done_q <= 1'b0;
      atom_done_q <= 1'b0;
      alloc_rd_q <= '0;
      atom_rd_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
      strobe_q <= strobe_d;
      rw_q <= rw_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      size_q <= size_d;
      alloc_done_q <= alloc_done_d;
      atom_done_q <= atom_done_d;
      alloc_rd_q <= alloc_rd_d;
      atom_rd_q <= atom_rd_d;
    end
  end
  assign alloc_done_o = alloc_done_q;
  assign alloc_data_o = alloc_rd_q;
  assign atom_done_o = atom_done_q;
  assign atom_data_o = atom_rd_q;
  assign mem_strobe_o = strobe_q;
  assign mem_addr_o = addr_q;
  assign mem_rw_o = rw_q;
  assign mem_data_o = wdata_q;
  assign mem_size_o = size_q;
  assign busy_o = state_q != S_IDLE;
  assign owner_o = owner_q;
endmodule

// File: tb/tb_dmm_port_arbiter.sv
// tb_dmm_port_arbiter: scoreboard bench with a reference memory, directed cases and random two-requester traffic.
module tb_dmm_port_arbiter;
  logic clk = 0, rst = 1;
  logic alloc_req_i = 0, alloc_rw_i = 0, atom_req_i = 0, atom_rw_i = 0, mem_done_i = 0;
  logic [31:0] alloc_addr_i = 0, alloc_data_i = 0, atom_addr_i = 0;
  logic [3:0] alloc_len_i = 0;
  logic [255:0] atom_data_i = 0, mem_data_i = 0;
  logic alloc_done_o, atom_done_o, mem_strobe_o, mem_rw_o, busy_o, owner_o;
  logic [31:0] alloc_data_o, mem_addr_o;
  logic [255:0] atom_data_o, mem_data_o;
  logic [7:0] mem_size_o;

  typedef struct packed {logic [31:0] addr; logic rw; logic [255:0] data; logic [7:0] size;} tx_t;
  typedef struct packed {logic own; logic [255:0] data; int cyc;} rsp_t;
  tx_t alloc_q[$], atom_q[$];
  rsp_t rsp_q[$];
  int checks = 0, fails = 0, cyc = 0, fixed_delay = 0;
  logic cur_own = 0, mdl_last = 1;
  bit mem_auto = 1, fixed_valid = 0;
  logic [255:0] fixed_line = 0;
  logic [3:0] own_log = 0;

  dmm_port_arbiter #(.WORD_LANE_LSB(224)) dut (
    .clk(clk), .rst(rst),
    .alloc_req_i(alloc_req_i), .alloc_addr_i(alloc_addr_i), .alloc_rw_i(alloc_rw_i),
    .alloc_data_i(alloc_data_i), .alloc_len_i(alloc_len_i), .alloc_done_o(alloc_done_o),
    .alloc_data_o(alloc_data_o), .atom_req_i(atom_req_i), .atom_addr_i(atom_addr_i),
    .atom_rw_i(atom_rw_i), .atom_data_i(atom_data_i), .atom_done_o(atom_done_o),
    .atom_data_o(atom_data_o), .mem_strobe_o(mem_strobe_o), .mem_addr_o(mem_addr_o),
    .mem_rw_o(mem_rw_o), .mem_data_o(mem_data_o), .mem_size_o(mem_size_o),
    .mem_done_i(mem_done_i), .mem_data_i(mem_data_i), .busy_o(busy_o), .owner_o(owner_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [255:0] rnd_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Reference memory: presents a read line with done and records what the requester must see one cycle later.
  task automatic mem_respond(input logic [255:0] line);
    mem_data_i = line;
    mem_done_i = 1;
    rsp_q.push_back('{cur_own, cur_own ? line : {224'b0, line[255:224]}, cyc + 1});
    @(negedge clk);
    mem_done_i = 0;
    mem_data_i = rnd_line();
  endtask

  initial forever begin
    @(negedge clk);
    if (mem_auto && mem_strobe_o && !rst) begin
      repeat (fixed_delay != 0 ? fixed_delay : int'($urandom_range(1, 4))) @(negedge clk);
      mem_respond(fixed_valid ? fixed_line : rnd_line());
    end
  end

  // Monitor: round-robin model picks the expected winner from the request levels seen at the grant edge.
  initial begin
    logic [1:0] r;
    logic e_own;
    tx_t cur, snap, e;
    rsp_t p;
    bit in_tx, bad;
    int last_stb;
    in_tx = 0; bad = 0; last_stb = -100; snap = '0;
    forever begin
      @(posedge clk);
      r = {atom_req_i, alloc_req_i};
      @(negedge clk);
      cur = {mem_addr_o, mem_rw_o, mem_data_o, mem_size_o};
      if (rst) begin
        mdl_last = 1; rsp_q.delete(); in_tx = 0; last_stb = -100;
      end else begin
        if (in_tx && cur != snap) bad = 1;
        if (mem_strobe_o) begin
          e_own = &r ? !mdl_last : r[1];
          chk(r != 0 && owner_o == e_own, "grant_owner", {r, owner_o}, {r, e_own});
          if ((e_own ? atom_q.size() : alloc_q.size()) == 0) begin
            checks++; fails++;
            $display("FAIL strobe_unexpected: owner %0d with no outstanding request", owner_o);
          end else begin
            e = e_own ? atom_q.pop_front() : alloc_q.pop_front();
            chk(cur == e, "strobe_fields", cur, e);
          end
          chk(cyc - last_stb >= 4, "strobe_spacing", cyc - last_stb, 4);
          last_stb = cyc; cur_own = e_own; snap = cur; in_tx = 1; bad = 0;
          own_log = {own_log[2:0], owner_o};
        end
        if (alloc_done_o || atom_done_o) begin
          if (rsp_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_done: alloc %0d atom %0d", alloc_done_o, atom_done_o);
          end else begin
            p = rsp_q.pop_front();
            chk({alloc_done_o, atom_done_o} == (p.own ? 2'b01 : 2'b10), "done_owner",
                {alloc_done_o, atom_done_o}, p.own ? 2'b01 : 2'b10);
            chk((p.own ? atom_data_o : {224'b0, alloc_data_o}) == p.data, "done_data",
                p.own ? atom_data_o : {224'b0, alloc_data_o}, p.data);
            chk(cyc == p.cyc, "done_cycle", cyc, p.cyc);
            chk(!bad, "fields_stable", bad, 0);
            mdl_last = p.own; in_tx = 0;
          end
        end
      end
    end
  end

  task automatic wait_done(input bit which);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(which ? atom_done_o : alloc_done_o) && t < 64);
    if (!(which ? atom_done_o : alloc_done_o)) begin
      checks++; fails++;
      $display("FAIL done_timeout: requester %0d saw no done in %0d cycles", which, t);
    end
  endtask

  task automatic wait_strobe();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!mem_strobe_o && t < 64);
    if (!mem_strobe_o) begin
      checks++; fails++;
      $display("FAIL strobe_timeout: no strobe in %0d cycles", t);
    end
  endtask

  task automatic alloc_txn(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] l);
    alloc_addr_i = a; alloc_rw_i = w; alloc_data_i = d; alloc_len_i = l;
    alloc_q.push_back('{a, w, {d, 224'b0}, {4'b0, l}});
    alloc_req_i = 1;
    wait_done(0);
    alloc_req_i = 0;
  endtask

  task automatic atom_txn(input logic [31:0] a, input logic w, input logic [255:0] d);
    atom_addr_i = a; atom_rw_i = w; atom_data_i = d;
    atom_q.push_back('{a, w, d, 8'd8});
    atom_req_i = 1;
    wait_done(1);
    atom_req_i = 0;
  endtask

  task automatic alloc_agent(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      alloc_txn($urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
    end
  endtask

  task automatic atom_agent(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      atom_txn($urandom, 1'($urandom_range(0, 1)), rnd_line());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk(~|{alloc_done_o, alloc_data_o, atom_done_o, atom_data_o, mem_strobe_o, mem_addr_o, mem_rw_o,
           mem_data_o, mem_size_o, busy_o, owner_o}, "reset_outputs",
        {busy_o, owner_o, mem_strobe_o, mem_size_o, mem_addr_o}, 0);
    rst = 0;
    @(negedge clk);
    for (int k = 0; k < 2; k++)
      fork
        alloc_txn($urandom, 1, $urandom, 4'd4);
        atom_txn($urandom, 0, rnd_line());
      join
    chk(own_log == 4'b0101, "tie_order", own_log, 4'b0101);

    fixed_delay = 3;
    alloc_txn(32'h7000_0010, 1, 32'hDEAD_BEEF, 4'd4);
    fixed_valid = 1;
    fixed_line = {4{64'h0123_4567_89AB_CDEF}};
    atom_txn(32'h7000_0040, 0, rnd_line());
    chk(atom_data_o == fixed_line, "atom_read_line", atom_data_o, fixed_line);
    @(negedge clk);
    chk(!atom_done_o, "atom_done_single", atom_done_o, 0);
    fixed_line = {32'hA5A5_A5A5, {224{1'b1}}};
    alloc_txn(32'h7000_0020, 0, $urandom, 4'd4);
    chk(alloc_data_o == 32'hA5A5_A5A5, "alloc_lane", alloc_data_o, 32'hA5A5_A5A5);
    fixed_valid = 0;
    fixed_delay = 0;

    mem_auto = 0;
    @(negedge clk);
    mem_done_i = 1;
    @(negedge clk);
    mem_done_i = 0;
    chk(!busy_o, "idle_spurious_busy", busy_o, 0);
    alloc_addr_i = 32'h7000_0100; alloc_rw_i = 1; alloc_data_i = 32'h1234_5678; alloc_len_i = 4'd2;
    alloc_q.push_back('{32'h7000_0100, 1'b1, {32'h1234_5678, 224'b0}, 8'd2});
    alloc_req_i = 1;
    wait_strobe();
    mem_done_i = 1;
    @(negedge clk);
    mem_done_i = 0;
    chk(busy_o && !alloc_done_o, "issue_spurious_ignored", {busy_o, alloc_done_o}, 2'b10);
    for (int k = 0; k < 3; k++) begin
      alloc_addr_i = $urandom;
      @(negedge clk);
      chk(mem_addr_o == 32'h7000_0100, "addr_stable_wait", mem_addr_o, 32'h7000_0100);
    end
    mem_respond(rnd_line());
    chk(alloc_done_o, "manual_done", alloc_done_o, 1);
    alloc_req_i = 0;

    @(negedge clk);
    alloc_addr_i = 32'h7000_0200; alloc_rw_i = 0; alloc_len_i = 4'd4;
    alloc_q.push_back('{32'h7000_0200, 1'b0, {alloc_data_i, 224'b0}, 8'd4});
    alloc_req_i = 1;
    wait_strobe();
    @(negedge clk);
    rst = 1;
    alloc_req_i = 0;
    #1;
    chk(~|{alloc_done_o, atom_done_o, mem_strobe_o, mem_addr_o, mem_rw_o, mem_data_o, mem_size_o, busy_o, owner_o},
        "midtx_reset_outputs", {busy_o, owner_o, mem_strobe_o, mem_size_o, mem_addr_o}, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    mem_done_i = 1;
    @(negedge clk);
    mem_done_i = 0;
    repeat (3) @(negedge clk);
    chk(!busy_o && !alloc_done_o, "late_done_ignored", {busy_o, alloc_done_o}, 0);

    mem_auto = 1;
    fork
      alloc_agent(20);
      atom_agent(20);
    join
    repeat (5) @(negedge clk);
    chk(alloc_q.size() + atom_q.size() + rsp_q.size() == 0, "queues_drained",
        alloc_q.size() + atom_q.size() + rsp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
